// File: rtl/ir_frame_encoder_pkg.sv
// Shared IR symbol encoding (mark/space codes) and encoder/issuer state types.
// IR_FRAME_ENCODER_REPEAT_EN adds the repeat-code leader-space state.
package ir_pkg;

    localparam logic [4:0] IR_SYM_IDLE = 5'h10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_M,
        S_LEAD_S,
        S_BIT_M,
        S_BIT_S,
        S_STOP_M,
        S_END
`ifdef IR_FRAME_ENCODER_REPEAT_EN
        , S_REP_S
`endif
    } ir_enc_state_e;

    typedef enum logic [1:0] {
        ISS_IDLE,
        ISS_GUARD,
        ISS_WAIT
    } ir_iss_state_e;

    // Lengths are 1..15, so neither direction can wrap the 5-bit code.
    function automatic logic [4:0] mark(input logic [3:0] n);
        return IR_SYM_IDLE + {1'b0, n};
    endfunction

    function automatic logic [4:0] space(input logic [3:0] n);
        return IR_SYM_IDLE - {1'b0, n};
    endfunction

endpackage

// File: rtl/ir_frame_encoder_if.sv
// Frame-offer and modulator-symbol signals of the IR frame encoder.
// slave = encoder side, master = frame source plus modulator done return.
interface ir_frame_encoder_if;
    logic [31:0] frame_data;
    logic [5:0]  frame_bits;
    logic        frame_valid;
    logic        frame_ready;
    logic        rep_req;
    logic [4:0]  sym;
    logic        sym_load;
    logic        sym_done;
    logic        busy;
    logic        frame_sent;

    modport slave (
        input  frame_data, frame_bits, frame_valid, rep_req, sym_done,
        output frame_ready, sym, sym_load, busy, frame_sent
    );

    modport master (
        output frame_data, frame_bits, frame_valid, rep_req, sym_done,
        input  frame_ready, sym, sym_load, busy, frame_sent
    );
endinterface

// File: rtl/ir_frame_encoder_sym_issuer.sv
// Issues one symbol to the modulator: load strobe, one guard edge, then waits for done.
module ir_sym_issuer
    import ir_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [4:0] sym_in,
    output logic [4:0] sym,
    output logic       sym_load,
    input  logic       sym_done,
    output logic       complete
);

    ir_iss_state_e state;

    // Combinational so the FSM can queue the next symbol on the same edge.
    assign complete = (state == ISS_WAIT) && sym_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ISS_IDLE;
            sym      <= IR_SYM_IDLE;
            sym_load <= 1'b0;
        end else begin
            sym_load <= 1'b0;
            case (state)
                ISS_IDLE: begin
                    if (start) begin
                        sym      <= sym_in;
                        sym_load <= 1'b1;
                        state    <= ISS_GUARD;
                    end
                end
                // The modulator latches the load on this edge; its done is stale here.
                ISS_GUARD: state <= ISS_WAIT;
                ISS_WAIT: begin
                    if (sym_done) state <= ISS_IDLE;
                end
                default: state <= ISS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ir_frame_encoder.sv
// IR frame encoder: serialises leader, LSB-first data bits and stop mark into modulator symbols.
// IR_FRAME_ENCODER_REPEAT_EN enables the repeat-code frame on rep_req.
//
// state    | meaning
// IDLE     | frame_ready high, waiting for frame_valid (or rep_req)
// LEAD_M   | leader mark in flight
// LEAD_S   | leader space in flight
// REP_S    | repeat-code leader space in flight (repeat build only)
// BIT_M    | data-bit mark in flight
// BIT_S    | data-bit space in flight, shift/count on completion
// STOP_M   | stop mark in flight
// END      | frame_sent pulse, back to IDLE
module ir_frame_encoder
    import ir_pkg::*;
#(
    parameter logic [3:0] LEAD_MARK  = 4'd15,
    parameter logic [3:0] LEAD_SPACE = 4'd8,
    parameter logic [3:0] BIT_MARK   = 4'd1,
    parameter logic [3:0] SPACE0     = 4'd1,
    parameter logic [3:0] SPACE1     = 4'd3,
    parameter logic [3:0] REP_SPACE  = 4'd4
) (
    input  logic                  clk,
    input  logic                  rstn,
    ir_frame_encoder_if.slave     bus
);

    ir_enc_state_e state;
    logic [31:0]   shift;
    logic [5:0]    bit_cnt;
    logic          start;
    logic [4:0]    next_sym;
    logic          complete;
    logic          frame_ready_q;
    logic          busy_q;
    logic          frame_sent_q;

    assign bus.frame_ready = frame_ready_q;
    assign bus.busy        = busy_q;
    assign bus.frame_sent  = frame_sent_q;

`ifdef IR_FRAME_ENCODER_REPEAT_EN
    logic rep_mode;
`else
    logic unused_rep;
    assign unused_rep = ^{bus.rep_req, REP_SPACE};
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            shift         <= '0;
            bit_cnt       <= '0;
            start         <= 1'b0;
            next_sym      <= IR_SYM_IDLE;
            frame_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            frame_sent_q  <= 1'b0;
`ifdef IR_FRAME_ENCODER_REPEAT_EN
            rep_mode      <= 1'b0;
`endif
        end else begin
            start        <= 1'b0;
            frame_sent_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.frame_valid) begin
                        shift         <= bus.frame_data;
                        bit_cnt       <= (bus.frame_bits == 6'd0) ? 6'd32 : bus.frame_bits;
                        state         <= S_LEAD_M;
                        start         <= 1'b1;
                        next_sym      <= mark(LEAD_MARK);
                        frame_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                    end
`ifdef IR_FRAME_ENCODER_REPEAT_EN
                    else if (bus.rep_req) begin
                        rep_mode      <= 1'b1;
                        state         <= S_LEAD_M;
                        start         <= 1'b1;
                        next_sym      <= mark(LEAD_MARK);
                        frame_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                    end
`endif
                end
                S_LEAD_M: begin
                    if (complete) begin
                        start <= 1'b1;
`ifdef IR_FRAME_ENCODER_REPEAT_EN
                        if (rep_mode) begin
                            state    <= S_REP_S;
                            next_sym <= space(REP_SPACE);
                        end else begin
                            state    <= S_LEAD_S;
                            next_sym <= space(LEAD_SPACE);
                        end
`else
                        state    <= S_LEAD_S;
                        next_sym <= space(LEAD_SPACE);
`endif
                    end
                end
`ifdef IR_FRAME_ENCODER_REPEAT_EN
                S_REP_S: begin
                    if (complete) begin
                        state    <= S_STOP_M;
                        start    <= 1'b1;
                        next_sym <= mark(BIT_MARK);
                    end
                end
`endif
                S_LEAD_S: begin
                    if (complete) begin
                        state    <= S_BIT_M;
                        start    <= 1'b1;
                        next_sym <= mark(BIT_MARK);
                    end
                end
                S_BIT_M: begin
                    if (complete) begin
                        state    <= S_BIT_S;
                        start    <= 1'b1;
                        next_sym <= shift[0] ? space(SPACE1) : space(SPACE0);
                    end
                end
                S_BIT_S: begin
                    if (complete) begin
                        shift    <= {1'b0, shift[31:1]};
                        bit_cnt  <= bit_cnt - 6'd1;
                        start    <= 1'b1;
                        next_sym <= mark(BIT_MARK);
                        // Counter still holds the pre-decrement value here.
                        state    <= (bit_cnt != 6'd1) ? S_BIT_M : S_STOP_M;
                    end
                end
                S_STOP_M: begin
                    if (complete) state <= S_END;
                end
                S_END: begin
                    state         <= S_IDLE;
                    frame_sent_q  <= 1'b1;
                    frame_ready_q <= 1'b1;
                    busy_q        <= 1'b0;
`ifdef IR_FRAME_ENCODER_REPEAT_EN
                    rep_mode      <= 1'b0;
`endif
                end
                default: begin
                    state         <= S_IDLE;
                    frame_ready_q <= 1'b1;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    ir_sym_issuer u_issuer (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .sym_in   (next_sym),
        .sym      (bus.sym),
        .sym_load (bus.sym_load),
        .sym_done (bus.sym_done),
        .complete (complete)
    );

endmodule

// File: tb/tb_ir_frame_encoder.sv
// Directed bench for ir_frame_encoder; define IR_FRAME_ENCODER_REPEAT_EN to also cover repeat codes.
module tb_ir_frame_encoder;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ir_frame_encoder_if bus();

    ir_frame_encoder dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Modulator model: 0 = done low, 1 = done held high, 2 = done pulse sampled 6 edges after load.
    int done_mode = 0;
    int cyc = 0;
    int last_load = -100;
    int sent_cnt = 0;
    int sent_cyc = 0;
    logic [4:0] log_sym[$];
    int         log_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.sym_load) begin
            log_sym.push_back(bus.sym);
            log_cyc.push_back(cyc);
            last_load <= cyc;
        end
        if (bus.frame_sent) begin
            sent_cnt <= sent_cnt + 1;
            sent_cyc <= cyc;
        end
        case (done_mode)
            1:       bus.sym_done <= 1'b1;
            2:       bus.sym_done <= (cyc == last_load + 5);
            default: bus.sym_done <= 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] d, input logic [5:0] n, input logic valid, input logic rep);
        @(negedge clk);
        bus.frame_data  = d;
        bus.frame_bits  = n;
        bus.frame_valid = valid;
        bus.rep_req     = rep;
        @(posedge clk);
        #1;
        bus.frame_valid = 1'b0;
        bus.rep_req     = 1'b0;
    endtask

    task automatic wait_frame(input int base_sent, input int budget, input string tag);
        for (int i = 0; i < budget && sent_cnt == base_sent; i++) @(negedge clk);
        #1;
        check(tag, sent_cnt - base_sent, 1);
    endtask

    // Default-parameter symbol at position idx of an n-bit frame.
    function automatic logic [4:0] exp_sym(input int idx, input logic [31:0] d, input int n);
        if (idx == 0) return 5'h1F;
        if (idx == 1) return 5'h08;
        if (idx % 2 == 0) return 5'h11;
        return d[(idx - 3) / 2] ? 5'h0D : 5'h0F;
    endfunction

    int base, base_sent, acc_cyc, bad, n_at_reset;

    initial begin
        bus.frame_data  = '0;
        bus.frame_bits  = '0;
        bus.frame_valid = 1'b0;
        bus.rep_req     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_sym",   bus.sym, 5'h10);
        check("rst_load",  bus.sym_load, 1'b0);
        check("rst_ready", bus.frame_ready, 1'b1);
        check("rst_busy",  bus.busy, 1'b0);
        check("rst_sent",  bus.frame_sent, 1'b0);
        rstn = 1'b1;

        // 4-bit frame 0101, done held high
        done_mode = 1;
        repeat (2) @(negedge clk);
        base = log_sym.size();
        base_sent = sent_cnt;
        offer(32'h5, 6'd4, 1'b1, 1'b0);
        acc_cyc = cyc;
        check("t1_busy",  bus.busy, 1'b1);
        check("t1_ready", bus.frame_ready, 1'b0);
        wait_frame(base_sent, 200, "t1_done");
        check("t1_ready_end", bus.frame_ready, 1'b1);
        check("t1_count", log_sym.size() - base, 11);
        if (log_sym.size() - base == 11) begin
            check("t1_first_lat", log_cyc[base] - acc_cyc, 1);
            for (int i = 0; i < 11; i++)
                check($sformatf("t1_sym%0d", i), log_sym[base + i], exp_sym(i, 32'h5, 4));
            bad = 0;
            for (int i = 1; i < 11; i++)
                if (log_cyc[base + i] - log_cyc[base + i - 1] != 3) bad++;
            check("t1_cadence3", bad, 0);
            check("t1_sent_time", sent_cyc - log_cyc[base + 10], 3);
        end

        // frame_bits = 0 means 32 bits
        base = log_sym.size();
        base_sent = sent_cnt;
        offer(32'h1, 6'd0, 1'b1, 1'b0);
        wait_frame(base_sent, 400, "t2_done");
        check("t2_count", log_sym.size() - base, 67);
        if (log_sym.size() - base == 67) begin
            check("t2_first_space", log_sym[base + 3], 5'h0D);
            bad = 0;
            for (int i = 5; i < 67; i += 2)
                if (log_sym[base + i] !== 5'h0F) bad++;
            check("t2_zero_spaces", bad, 0);
            check("t2_stop", log_sym[base + 66], 5'h11);
        end

        // Slow modulator, mid-frame frame_valid ignored
        done_mode = 2;
        repeat (2) @(negedge clk);
        base = log_sym.size();
        base_sent = sent_cnt;
        offer(32'hA5, 6'd8, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        offer(32'hFFFF_FFFF, 6'd3, 1'b1, 1'b0);
        check("t3_ready_mid", bus.frame_ready, 1'b0);
        check("t3_busy_mid",  bus.busy, 1'b1);
        wait_frame(base_sent, 400, "t3_done");
        check("t3_count", log_sym.size() - base, 19);
        if (log_sym.size() - base == 19) begin
            bad = 0;
            for (int i = 0; i < 19; i++)
                if (log_sym[base + i] !== exp_sym(i, 32'hA5, 8)) bad++;
            check("t3_syms", bad, 0);
            bad = 0;
            for (int i = 1; i < 19; i++)
                if (log_cyc[base + i] - log_cyc[base + i - 1] != 7) bad++;
            check("t3_cadence7", bad, 0);
        end
        repeat (10) @(negedge clk);
        check("t3_no_restart", bus.busy, 1'b0);

        // Reset during the 3rd data bit
        base = log_sym.size();
        offer(32'hF, 6'd4, 1'b1, 1'b0);
        for (int i = 0; i < 200 && log_sym.size() - base < 7; i++) begin
            @(negedge clk);
            #1;
        end
        check("t4_reached_bit3", (log_sym.size() - base) >= 7, 1'b1);
        rstn = 1'b0;
        #1;
        check("t4_sym",   bus.sym, 5'h10);
        check("t4_load",  bus.sym_load, 1'b0);
        check("t4_ready", bus.frame_ready, 1'b1);
        check("t4_busy",  bus.busy, 1'b0);
        n_at_reset = log_sym.size();
        repeat (2) @(negedge clk);
        done_mode = 1;
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        check("t4_no_load", log_sym.size() - n_at_reset, 0);
        base = log_sym.size();
        base_sent = sent_cnt;
        offer(32'h2, 6'd2, 1'b1, 1'b0);
        wait_frame(base_sent, 200, "t4_done");
        check("t4_count", log_sym.size() - base, 7);
        if (log_sym.size() - base == 7) begin
            check("t4_leader", log_sym[base], 5'h1F);
            bad = 0;
            for (int i = 0; i < 7; i++)
                if (log_sym[base + i] !== exp_sym(i, 32'h2, 2)) bad++;
            check("t4_syms", bad, 0);
        end

`ifdef IR_FRAME_ENCODER_REPEAT_EN
        // Repeat code alone
        repeat (2) @(negedge clk);
        base = log_sym.size();
        base_sent = sent_cnt;
        offer(32'h0, 6'd1, 1'b0, 1'b1);
        wait_frame(base_sent, 200, "t5_done");
        check("t5_count", log_sym.size() - base, 3);
        if (log_sym.size() - base == 3) begin
            check("t5_sym0", log_sym[base],     5'h1F);
            check("t5_sym1", log_sym[base + 1], 5'h0C);
            check("t5_sym2", log_sym[base + 2], 5'h11);
        end

        // frame_valid wins over rep_req
        repeat (2) @(negedge clk);
        base = log_sym.size();
        base_sent = sent_cnt;
        offer(32'h1, 6'd1, 1'b1, 1'b1);
        wait_frame(base_sent, 200, "t6_done");
        check("t6_count", log_sym.size() - base, 5);
        if (log_sym.size() - base == 5) begin
            bad = 0;
            for (int i = 0; i < 5; i++)
                if (log_sym[base + i] !== exp_sym(i, 32'h1, 1)) bad++;
            check("t6_syms", bad, 0);
        end
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
